// File: rtl/stream_demux.sv
// ---------------------------------------------------------------------------
// stream_demux
//   Routes one valid/ready input stream to one of NUM_OUT output streams,
//   chosen by a per-beat select field. Each output owns a 2-entry FIFO, so a
//   stalled consumer only blocks beats addressed to it. Beats whose select is
//   out of range are accepted and dropped, and they set a sticky error flag.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : input beat present
//   in_ready   : input beat accepted when in_valid is also high
//   in_data    : input payload (N bits)
//   in_sel     : destination port index (SEL_W bits)
//   out_valid  : per-port valid, bit k belongs to port k
//   out_ready  : per-port ready from the consumers
//   out_data   : per-port payload, port k at [k*N +: N] (registered FIFO head)
//   beat_count : accepted in-range beats, wraps modulo 2**32
//   sel_err    : sticky, set when an out-of-range beat is accepted
// ---------------------------------------------------------------------------
module stream_demux #(
    parameter int N       = 32,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [NUM_OUT-1:0]     out_valid,
    input  logic [NUM_OUT-1:0]     out_ready,
    output logic [N*NUM_OUT-1:0]   out_data,
    output logic [31:0]            beat_count,
    output logic                   sel_err
);

    // One extra bit so NUM_OUT == 2**SEL_W is still representable.
    localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W+1)'(NUM_OUT);

    logic [N-1:0]       mem_q [NUM_OUT][2];
    logic [1:0]         cnt_q [NUM_OUT];
    logic [1:0]         cnt_d [NUM_OUT];
    logic [NUM_OUT-1:0] rd_ptr_q, rd_ptr_d;
    logic [NUM_OUT-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]        beat_count_q, beat_count_d;
    logic               sel_err_q, sel_err_d;

    logic [NUM_OUT-1:0] sel_hit;
    logic [NUM_OUT-1:0] push;
    logic [NUM_OUT-1:0] pop;
    logic               in_range;
    logic               accept;

    always_comb begin
        in_range = ({1'b0, in_sel} < NUM_OUT_L);
        in_ready = 1'b1;
        sel_hit  = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
            // A full FIFO still accepts when its consumer pops this cycle.
            if (sel_hit[k]) begin
                in_ready = (cnt_q[k] != 2'd2) || out_ready[k];
            end
        end
        accept = in_valid && in_ready;

        push     = '0;
        pop      = '0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            push[k]     = accept && sel_hit[k];
            pop[k]      = (cnt_q[k] != 2'd0) && out_ready[k];
            rd_ptr_d[k] = rd_ptr_q[k] ^ pop[k];
            wr_ptr_d[k] = wr_ptr_q[k] ^ push[k];
            cnt_d[k]    = cnt_q[k];
            case ({push[k], pop[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + 2'd1;
                2'b01:   cnt_d[k] = cnt_q[k] - 2'd1;
                default: cnt_d[k] = cnt_q[k];
            endcase
        end

        beat_count_d = beat_count_q + {31'd0, accept && in_range};
        sel_err_d    = sel_err_q | (accept && !in_range);
    end

    // Clock edge: FIFO storage, pointers, counters.
    // Storage is reset too so every out_data lane reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                cnt_q[k]    <= 2'd0;
                mem_q[k][0] <= '0;
                mem_q[k][1] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            beat_count_q <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                cnt_q[k] <= cnt_d[k];
                if (push[k]) begin
                    mem_q[k][wr_ptr_q[k]] <= in_data;
                end
            end
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            beat_count_q <= beat_count_d;
            sel_err_q    <= sel_err_d;
        end
    end

    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_valid[k]       = (cnt_q[k] != 2'd0);
            out_data[k*N +: N] = mem_q[k][rd_ptr_q[k]];
        end
    end

    assign beat_count = beat_count_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_stream_demux.sv
// ---------------------------------------------------------------------------
// tb_stream_demux
//   Directed and randomized bench for stream_demux (4 ports) plus a 3-port
//   instance used for the out-of-range select case. The reference model keeps
//   each port's FIFO as a tiny shift list (head at index 0).
// ---------------------------------------------------------------------------
module tb_stream_demux;

    localparam int N  = 32;
    localparam int NO = 4;
    localparam int SW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_data;
    logic [SW-1:0]     in_sel;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;
    logic [N*NO-1:0]   out_data;
    logic [31:0]       beat_count;
    logic              sel_err;

    logic              in_valid3;
    logic              in_ready3;
    logic [N-1:0]      in_data3;
    logic [1:0]        in_sel3;
    logic [2:0]        out_valid3;
    logic [2:0]        out_ready3;
    logic [N*3-1:0]    out_data3;
    logic [31:0]       beat_count3;
    logic              sel_err3;

    stream_demux #(.N(N), .NUM_OUT(NO), .SEL_W(SW)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_count(beat_count), .sel_err(sel_err)
    );

    stream_demux #(.N(N), .NUM_OUT(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_sel(in_sel3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .beat_count(beat_count3), .sel_err(sel_err3)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [31:0] mdata [NO][2];
    int          mcnt  [NO];
    logic [31:0] mbeat;
    logic        merr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NO; k++) begin
            mcnt[k]     = 0;
            mdata[k][0] = '0;
            mdata[k][1] = '0;
        end
        mbeat = '0;
        merr  = 1'b0;
    endtask

    function automatic logic model_ready();
        if (int'(in_sel) < NO)
            return (mcnt[int'(in_sel)] < 2) || out_ready[int'(in_sel)];
        return 1'b1;
    endfunction

    // Applied at the rising edge with the inputs that were held across it.
    task automatic model_step();
        logic acc;
        int   s;
        acc = in_valid && model_ready();
        for (int k = 0; k < NO; k++) begin
            if (mcnt[k] > 0 && out_ready[k]) begin
                mdata[k][0] = mdata[k][1];
                mcnt[k]--;
            end
        end
        if (acc) begin
            if (int'(in_sel) < NO) begin
                s = int'(in_sel);
                mdata[s][mcnt[s]] = in_data;
                mcnt[s]++;
                mbeat++;
            end else begin
                merr = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [NO-1:0] expv;
        for (int k = 0; k < NO; k++) expv[k] = (mcnt[k] != 0);
        chk("out_valid", 32'(out_valid), 32'(expv));
        for (int k = 0; k < NO; k++) begin
            if (mcnt[k] != 0)
                chk($sformatf("out_data[%0d]", k), out_data[k*N +: N], mdata[k][0]);
        end
        chk("in_ready", 32'(in_ready), 32'(model_ready()));
        chk("beat_count", beat_count, mbeat);
        chk("sel_err", 32'(sel_err), 32'(merr));
    endtask

    // Called at a falling edge after inputs are set.
    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic push_beat(input logic [SW-1:0] s, input logic [31:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = '0;
        out_ready  = '1;
        in_valid3  = 1'b0;
        in_data3   = '0;
        in_sel3    = '0;
        out_ready3 = '1;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'h0);
        for (int k = 0; k < NO; k++) chk($sformatf("rst out_data[%0d]", k), out_data[k*N +: N], 32'h0);
        chk("rst beat_count", beat_count, 32'h0);
        chk("rst sel_err", 32'(sel_err), 32'h0);
        chk("rst in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Single beat to port 2
        push_beat(5'd2, 32'hDEADBEEF);
        settle();
        chk("t1 in_ready", 32'(in_ready), 32'h1);
        advance();
        in_valid = 1'b0;
        settle();
        chk("t1 out_valid", 32'(out_valid), 32'h4);
        chk("t1 out_data2", out_data[2*N +: N], 32'hDEADBEEF);
        chk("t1 beat_count", beat_count, 32'h1);
        advance();
        settle();
        chk("t1 out_valid gone", 32'(out_valid), 32'h0);
        advance();

        // Backpressure on port 1
        out_ready = 4'b1101;
        push_beat(5'd1, 32'h11); settle(); chk("bp 0x11 ready", 32'(in_ready), 32'h1); advance();
        push_beat(5'd1, 32'h22); settle(); chk("bp 0x22 ready", 32'(in_ready), 32'h1); advance();
        push_beat(5'd1, 32'h33); settle(); chk("bp 0x33 stalled", 32'(in_ready), 32'h0); advance();
        out_ready = 4'b1111;
        settle();
        chk("bp 0x33 ready on pop", 32'(in_ready), 32'h1);
        chk("bp head 0x11", out_data[1*N +: N], 32'h11);
        advance();
        in_valid = 1'b0;
        settle(); chk("bp head 0x22", out_data[1*N +: N], 32'h22); advance();
        settle(); chk("bp head 0x33", out_data[1*N +: N], 32'h33); advance();
        settle(); chk("bp drained", 32'(out_valid), 32'h0); advance();

        // Isolation: port 0 full and stalled, port 3 still flows
        out_ready = 4'b1110;
        push_beat(5'd0, 32'h100); settle(); advance();
        push_beat(5'd0, 32'h200); settle(); advance();
        push_beat(5'd3, 32'hA5A5A5A5);
        settle();
        chk("iso in_ready", 32'(in_ready), 32'h1);
        advance();
        in_valid = 1'b0;
        settle();
        chk("iso port3 valid", 32'(out_valid[3]), 32'h1);
        chk("iso port3 data", out_data[3*N +: N], 32'hA5A5A5A5);
        chk("iso port0 head", out_data[0*N +: N], 32'h100);
        advance();
        out_ready = 4'b1111;
        repeat (3) begin settle(); advance(); end

        // Out-of-range select on both instances
        push_beat(5'd7, 32'h12345678);
        in_valid3 = 1'b1;
        in_sel3   = 2'd3;
        in_data3  = 32'hFFFF0000;
        settle();
        chk("oor in_ready", 32'(in_ready), 32'h1);
        chk("oor3 in_ready", 32'(in_ready3), 32'h1);
        advance();
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        repeat (3) begin
            settle();
            chk("oor sel_err", 32'(sel_err), 32'h1);
            chk("oor3 sel_err", 32'(sel_err3), 32'h1);
            chk("oor3 beat_count", beat_count3, 32'h0);
            chk("oor3 out_valid", 32'(out_valid3), 32'h0);
            chk("oor out_valid", 32'(out_valid), 32'h0);
            advance();
        end

        // Random soak
        for (int i = 0; i < 1000; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_sel    = SW'($urandom_range(NO-1));
            in_data   = $urandom;
            out_ready = NO'($urandom);
            settle();
            advance();
        end
        in_valid = 1'b0;
        settle();
        chk("soak beat_count total", beat_count, mbeat);

        // Asynchronous reset while ports 0 and 1 hold two beats each
        out_ready = 4'b0000;
        repeat (2) begin settle(); advance(); end
        push_beat(5'd0, 32'hA0); settle(); advance();
        push_beat(5'd0, 32'hA1); settle(); advance();
        push_beat(5'd1, 32'hB0); settle(); advance();
        push_beat(5'd1, 32'hB1); settle(); advance();
        in_valid = 1'b0;
        settle();
        chk("pre-rst out_valid", 32'(out_valid & 4'b0011), 32'h3);
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'h0);
        chk("async rst beat_count", beat_count, 32'h0);
        chk("async rst sel_err", 32'(sel_err), 32'h0);
        chk("async rst out_data0", out_data[0*N +: N], 32'h0);
        chk("async rst in_ready", 32'(in_ready), 32'h1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Traffic resumes
        out_ready = 4'b1111;
        push_beat(5'd2, 32'hCAFE0001); settle(); advance();
        in_valid = 1'b0;
        settle();
        chk("resume out_data2", out_data[2*N +: N], 32'hCAFE0001);
        chk("resume beat_count", beat_count, 32'h1);
        advance();
        for (int i = 0; i < 200; i++) begin
            in_valid  = ($urandom_range(1) != 0);
            in_sel    = SW'($urandom_range(NO-1));
            in_data   = $urandom;
            out_ready = NO'($urandom);
            settle();
            advance();
        end
        in_valid = 1'b0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
